// File: rtl/bta_operand_loader_if.sv
// Stream-in / bank-out bundle between the operand source, the loader and the tree adder.
interface bta_operand_loader_if #(
    parameter int M = 16
);
    logic         in_valid;
    logic [M-1:0] in_data;
    logic         in_ready;
    logic         clear;
    logic [M-1:0] op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
    logic         c0;
    logic         launch;
    logic         busy;
    logic         res_valid;
    logic [2:0]   slot_cnt;

    modport master (
        output in_valid, in_data, clear,
        input  in_ready, op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h,
        input  c0, launch, busy, res_valid, slot_cnt
    );

    modport slave (
        input  in_valid, in_data, clear,
        output in_ready, op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h,
        output c0, launch, busy, res_valid, slot_cnt
    );
endinterface

// File: rtl/bta_operand_loader.sv
// Collects eight operands into a bank, holds it steady for the tree adder's latency,
// then flags the adder result as valid and reopens for the next bank.
module bta_operand_loader #(
    parameter int M    = 16,
    parameter int HOLD = 40
) (
    input logic                 clk,
    input logic                 rst_n,
    bta_operand_loader_if.slave bus
);
    typedef enum logic {
        S_LOAD,
        S_HOLD
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    state_t       state;
    logic [M-1:0] bank [8];
    logic [7:0]   hold_cnt;
    logic [2:0]   slot_cnt;
    logic         launch;
    logic         res_valid;
    logic         accept;

    // Ready is combinational so that clear blocks an accept in the same cycle.
    assign bus.in_ready = rst_n & (state == S_LOAD) & ~bus.clear;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            hold_cnt  <= '0;
            slot_cnt  <= '0;
            launch    <= 1'b0;
            res_valid <= 1'b0;
            // NOTE: the bank is only eight registers and its reset value is observable
            // on op_a..op_h, so it is reset like any other state.
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; every right-hand side below
            // reads the pre-edge value, which is what makes slot_cnt index the old slot.
            launch    <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (bus.clear) begin
                        slot_cnt <= '0;
                    end else if (accept) begin
                        bank[slot_cnt] <= bus.in_data;
                        if (slot_cnt == 3'd7) begin
                            slot_cnt <= '0;
                            state    <= S_HOLD;
                            hold_cnt <= HOLD_LOAD;
                            launch   <= 1'b1;
                        end else begin
                            slot_cnt <= slot_cnt + 3'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.clear) begin
                        state <= S_LOAD;
                    end else if (hold_cnt == 8'd0) begin
                        state     <= S_LOAD;
                        res_valid <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign bus.op_a      = bank[0];
    assign bus.op_b      = bank[1];
    assign bus.op_c      = bank[2];
    assign bus.op_d      = bank[3];
    assign bus.op_e      = bank[4];
    assign bus.op_f      = bank[5];
    assign bus.op_g      = bank[6];
    assign bus.op_h      = bank[7];
    assign bus.c0        = 1'b0;
    assign bus.launch    = launch;
    assign bus.busy      = (state == S_HOLD);
    assign bus.res_valid = res_valid;
    assign bus.slot_cnt  = slot_cnt;
endmodule

// File: tb/tb_bta_operand_loader.sv
// Directed bench: a HOLD=40 loader for the main sequences and a HOLD=1 loader for async reset.
module tb_bta_operand_loader;
    localparam int M = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;
    always #5 clk = ~clk;

    bta_operand_loader_if #(.M(M)) ba ();
    bta_operand_loader_if #(.M(M)) bb ();

    bta_operand_loader #(.M(M), .HOLD(40)) dut_a (.clk(clk), .rst_n(rst_n),  .bus(ba));
    bta_operand_loader #(.M(M), .HOLD(1))  dut_b (.clk(clk), .rst_n(rst_nb), .bus(bb));

    int errors = 0;
    int checks = 0;
    int launch_a = 0;
    int res_a = 0;
    int res_b = 0;

    always @(posedge clk) begin
        if (ba.launch === 1'b1)    launch_a <= launch_a + 1;
        if (ba.res_valid === 1'b1) res_a    <= res_a + 1;
        if (bb.res_valid === 1'b1) res_b    <= res_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tree adder model: exact sum of the eight slots plus carry-in, M+3 bits wide.
    function automatic logic [M+2:0] sum8(input logic [M-1:0] a, b, c, d, e, f, g, h,
                                          input logic cin);
        return (M+3)'(a) + (M+3)'(b) + (M+3)'(c) + (M+3)'(d)
             + (M+3)'(e) + (M+3)'(f) + (M+3)'(g) + (M+3)'(h) + (M+3)'(cin);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [M-1:0] d);
        int n = 0;
        ba.in_valid = 1'b1;
        ba.in_data  = d;
        #1;
        while (ba.in_ready !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) check("send_a_timeout", 32'(n), 32'd0);
        tick;
        ba.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [M-1:0] d);
        int n = 0;
        bb.in_valid = 1'b1;
        bb.in_data  = d;
        #1;
        while (bb.in_ready !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) check("send_b_timeout", 32'(n), 32'd0);
        tick;
        bb.in_valid = 1'b0;
    endtask

    // Called in the launch cycle; returns cycles until res_valid and busy cycles seen.
    task automatic wait_res_a(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (ba.res_valid !== 1'b1 && cyc < 500) begin
            if (ba.busy === 1'b1) busy_cyc++;
            tick;
            cyc++;
        end
        if (cyc >= 500) check("res_valid_timeout", 32'(cyc), 32'd40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, busy_cyc, l0, r0, bad;
        logic [M-1:0] exp_a [8];
        logic [M-1:0] got_a [8];
        logic [M-1:0] prev_a;

        ba.in_valid = 1'b0; ba.in_data = '0; ba.clear = 1'b0;
        bb.in_valid = 1'b0; bb.in_data = '0; bb.clear = 1'b0;
        rst_n = 1'b0;
        rst_nb = 1'b0;
        #12;
        ba.in_valid = 1'b1;
        #1;
        check("rst_in_ready", 32'(ba.in_ready), 32'd0);
        check("rst_slot_cnt", 32'(ba.slot_cnt), 32'd0);
        check("rst_op_a", 32'(ba.op_a), 32'd0);
        check("rst_busy_launch_res", {29'd0, ba.busy, ba.launch, ba.res_valid}, 32'd0);
        check("c0", 32'(ba.c0), 32'd0);
        ba.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rst_nb = 1'b1;

        // Bank 1..8
        for (int i = 0; i < 8; i++) begin
            send_a(M'(i + 1));
            if (i < 7) check("t1_slot_cnt", 32'(ba.slot_cnt), 32'(i + 1));
        end
        check("t1_launch", 32'(ba.launch), 32'd1);
        check("t1_busy", 32'(ba.busy), 32'd1);
        check("t1_slot_wrap", 32'(ba.slot_cnt), 32'd0);
        got_a = '{ba.op_a, ba.op_b, ba.op_c, ba.op_d, ba.op_e, ba.op_f, ba.op_g, ba.op_h};
        for (int i = 0; i < 8; i++) check("t1_slot", 32'(got_a[i]), 32'(i + 1));
        wait_res_a(cyc, busy_cyc);
        check("t1_res_latency", 32'(cyc), 32'd40);
        check("t1_busy_cycles", 32'(busy_cyc), 32'd40);
        check("t1_busy_at_res", 32'(ba.busy), 32'd0);
        check("t1_ready_at_res", 32'(ba.in_ready), 32'd1);
        check("t1_sum", 32'(sum8(ba.op_a, ba.op_b, ba.op_c, ba.op_d,
                                 ba.op_e, ba.op_f, ba.op_g, ba.op_h, ba.c0)), 32'd36);
        check("t1_launch_count", 32'(launch_a), 32'd1);

        // All-ones bank: widest sum
        for (int i = 0; i < 8; i++) send_a(16'hFFFF);
        check("t2_launch", 32'(ba.launch), 32'd1);
        got_a = '{ba.op_a, ba.op_b, ba.op_c, ba.op_d, ba.op_e, ba.op_f, ba.op_g, ba.op_h};
        for (int i = 0; i < 8; i++) check("t2_slot", 32'(got_a[i]), 32'h0000FFFF);
        wait_res_a(cyc, busy_cyc);
        check("t2_res_latency", 32'(cyc), 32'd40);
        check("t2_sum", 32'(sum8(ba.op_a, ba.op_b, ba.op_c, ba.op_d,
                                 ba.op_e, ba.op_f, ba.op_g, ba.op_h, ba.c0)), 32'h7FFF8);

        // Clear after five accepts, then a full bank of 10..80
        l0 = launch_a;
        for (int i = 0; i < 5; i++) send_a(M'(i + 1));
        check("t3_slot_cnt5", 32'(ba.slot_cnt), 32'd5);
        ba.clear = 1'b1; ba.in_valid = 1'b1; ba.in_data = 16'h0099;
        #1;
        check("t3_ready_clear", 32'(ba.in_ready), 32'd0);
        tick;
        ba.clear = 1'b0; ba.in_valid = 1'b0;
        check("t3_slot_cnt_clr", 32'(ba.slot_cnt), 32'd0);
        check("t3_op_a_kept", 32'(ba.op_a), 32'd1);
        check("t3_op_f_kept", 32'(ba.op_f), 32'h0000FFFF);
        for (int i = 0; i < 8; i++) begin
            send_a(M'(10 * (i + 1)));
            check("t3_slot_cnt", 32'(ba.slot_cnt), 32'((i + 1) % 8));
        end
        check("t3_launch", 32'(ba.launch), 32'd1);
        exp_a = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
        got_a = '{ba.op_a, ba.op_b, ba.op_c, ba.op_d, ba.op_e, ba.op_f, ba.op_g, ba.op_h};
        for (int i = 0; i < 8; i++) check("t3_slot", 32'(got_a[i]), 32'(exp_a[i]));
        wait_res_a(cyc, busy_cyc);
        check("t3_one_launch", 32'(launch_a - l0), 32'd1);

        // Bank 5..12 again so HOLD can be probed with in_valid asserted
        for (int i = 0; i < 8; i++) send_a(M'(i + 5));
        prev_a = ba.op_a;
        ba.in_valid = 1'b1; ba.in_data = 16'h1234;
        #1;
        bad = 0;
        cyc = 0;
        while (ba.res_valid !== 1'b1 && cyc < 500) begin
            if (ba.in_ready !== 1'b0) bad++;
            if (ba.op_a !== prev_a) bad++;
            tick;
            cyc++;
        end
        check("t4_hold_frozen", 32'(bad), 32'd0);
        check("t4_hold_len", 32'(cyc), 32'd40);
        check("t4_ready_at_res", 32'(ba.in_ready), 32'd1);
        tick;
        ba.in_valid = 1'b0;
        check("t4_op_a_new", 32'(ba.op_a), 32'h1234);
        check("t4_slot_cnt", 32'(ba.slot_cnt), 32'd1);

        // Finish that bank, then clear at HOLD cycle 10
        for (int i = 0; i < 7; i++) send_a(M'(i + 2));
        check("t5_launch", 32'(ba.launch), 32'd1);
        repeat (10) tick;
        check("t5_busy_c10", 32'(ba.busy), 32'd1);
        ba.clear = 1'b1;
        tick;
        ba.clear = 1'b0;
        #1;
        check("t5_busy_drop", 32'(ba.busy), 32'd0);
        check("t5_ready", 32'(ba.in_ready), 32'd1);
        check("t5_slot_cnt", 32'(ba.slot_cnt), 32'd0);
        r0 = res_a;
        l0 = launch_a;
        repeat (100) tick;
        check("t5_no_res", 32'(res_a - r0), 32'd0);
        check("t5_no_launch", 32'(launch_a - l0), 32'd0);

        // HOLD=1 instance: async reset in the hold cycle
        for (int i = 0; i < 8; i++) send_b(M'(16'h100 + i));
        check("t6_launch", 32'(bb.launch), 32'd1);
        check("t6_busy", 32'(bb.busy), 32'd1);
        #2;
        rst_nb = 1'b0;
        #1;
        check("t6_rst_busy", 32'(bb.busy), 32'd0);
        check("t6_rst_launch", 32'(bb.launch), 32'd0);
        check("t6_rst_op_a", 32'(bb.op_a), 32'd0);
        check("t6_rst_op_h", 32'(bb.op_h), 32'd0);
        bb.in_valid = 1'b1;
        repeat (3) tick;
        check("t6_rst_ready", 32'(bb.in_ready), 32'd0);
        check("t6_no_res", 32'(res_b), 32'd0);
        bb.in_valid = 1'b0;
        @(negedge clk);
        rst_nb = 1'b1;
        for (int i = 0; i < 8; i++) send_b(M'(i + 1));
        check("t6_relaunch", 32'(bb.launch), 32'd1);
        tick;
        check("t6_res_next", 32'(bb.res_valid), 32'd1);
        check("t6_busy_off", 32'(bb.busy), 32'd0);
        check("t6_sum", 32'(sum8(bb.op_a, bb.op_b, bb.op_c, bb.op_d,
                                 bb.op_e, bb.op_f, bb.op_g, bb.op_h, bb.c0)), 32'd36);
        tick;
        check("t6_res_pulse", 32'(bb.res_valid), 32'd0);
        check("t6_res_count", 32'(res_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
